// File: rtl/pulse_rate_monitor.sv
// -----------------------------------------------------------------------------
// pulse_rate_monitor
//
// Heart-rate measurement core. Debounced sensor edges are counted over a
// programmable window, scaled to beats per minute, compared against alarm
// thresholds and shown on a multiplexed 7-segment display.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   start             begin a measurement (taken in IDLE only)
//   cls               synchronous abort/clear, overrides start
//   cont              restart automatically after each capture
//   pulse_in          asynchronous sensor pulse
//   mode              alarm mode: 00 off, 01 high, 10 low, 11 band
//   thr_lo, thr_hi    alarm thresholds
//   bpm, valid        last captured rate and its one-cycle update strobe
//   alarm             alarm flag, held between captures
//   en_count, en_cap  FSM phase indicators (counting / capture cycle)
//   clear, busy       clear cycle indicator / FSM not idle
//   seg, an           active-high segments (seg[0]=a), active-low digit select
// -----------------------------------------------------------------------------
module pulse_rate_monitor #(
    parameter int CNT_W      = 8,
    parameter int DIGITS     = 3,
    parameter int WIN_CYCLES = 100_000_000,
    parameter int SCALE      = 6,
    parameter int LOCKOUT    = 2_000_000,
    parameter int REFRESH    = 10_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cls,
    input  logic              cont,
    input  logic              pulse_in,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  thr_lo,
    input  logic [CNT_W-1:0]  thr_hi,
    output logic [CNT_W-1:0]  bpm,
    output logic              valid,
    output logic              alarm,
    output logic              en_count,
    output logic              en_cap,
    output logic              clear,
    output logic              busy,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int WIN_W    = $clog2(WIN_CYCLES + 1);
    localparam int LOCK_W   = $clog2(LOCKOUT + 1);
    localparam int PROD_W   = CNT_W + $clog2(SCALE + 1);
    // Enough BCD digits for any CNT_W-bit value, and never fewer than shown.
    localparam int BCD_NEED = (CNT_W + 2) / 3;
    localparam int BCD_D    = (BCD_NEED > DIGITS) ? BCD_NEED : DIGITS;
    localparam int BCD_W    = 4 * BCD_D;
    localparam int SH_W     = $clog2(CNT_W + 1);
    localparam int REF_W    = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLEAR   = 2'd1,
        S_COUNT   = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_sync;
    logic                r_sync_d;
    logic                w_edge;
    logic                w_accept;
    logic [WIN_W-1:0]    r_win;
    logic                w_win_done;
    logic [CNT_W-1:0]    r_pulse_cnt;
    logic [LOCK_W-1:0]   r_lock;
    logic [PROD_W-1:0]   w_product;
    logic [CNT_W-1:0]    w_bpm_sat;
    logic                w_alarm_nxt;
    logic [CNT_W-1:0]    r_bpm;
    logic                r_valid;
    logic                r_alarm;
    logic                r_conv;
    logic [CNT_W-1:0]    r_bin;
    logic [BCD_W-1:0]    r_bcd;
    logic [BCD_W-1:0]    w_bcd_adj;
    logic [BCD_W-1:0]    w_bcd_shift;
    logic [SH_W-1:0]     r_sh_cnt;
    logic [4*DIGITS-1:0] r_digits;
    logic [REF_W-1:0]    r_ref;
    logic [IDX_W-1:0]    r_idx;
    logic [DIGITS-1:0]   w_blank_mask;
    logic [3:0]          w_digit;
    logic [DIGITS-1:0]   w_an;
    logic [6:0]          w_seg;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // ---------------------------------------------------------------- input path
    // NOTE: state is updated with non-blocking assignments so every flop in the
    // chain samples the pre-edge value; blocking here would collapse the
    // synchroniser into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= 2'b00;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], pulse_in};
            r_sync_d <= r_sync[1];
        end
    end

    assign w_edge   = r_sync[1] & ~r_sync_d;
    assign w_accept = en_count & w_edge & (r_lock == '0);

    // ---------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    assign w_win_done = (r_win == WIN_W'(WIN_CYCLES - 1));

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start)      w_state_nxt = S_CLEAR;
            S_CLEAR:                   w_state_nxt = S_COUNT;
            S_COUNT:   if (w_win_done) w_state_nxt = S_CAPTURE;
            S_CAPTURE:                 w_state_nxt = cont ? S_CLEAR : S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
        if (cls) w_state_nxt = S_IDLE;
    end

    assign clear    = (r_state == S_CLEAR);
    assign en_count = (r_state == S_COUNT);
    assign en_cap   = (r_state == S_CAPTURE);
    assign busy     = (r_state != S_IDLE);

    // ------------------------------------------ window timer, pulses, lockout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win       <= '0;
            r_pulse_cnt <= '0;
            r_lock      <= '0;
        end else if (clear) begin
            r_win       <= '0;
            r_pulse_cnt <= '0;
            r_lock      <= '0;
        end else begin
            if (en_count) r_win <= r_win + 1'b1;
            if (w_accept) begin
                if (r_pulse_cnt != '1) r_pulse_cnt <= r_pulse_cnt + 1'b1;
                r_lock <= LOCK_W'(LOCKOUT - 1);
            end else if (r_lock != '0) begin
                r_lock <= r_lock - 1'b1;
            end
        end
    end

    // ------------------------------------------------------- capture and alarm
    // Product is formed at full width so overflow saturates instead of wrapping.
    assign w_product = PROD_W'(r_pulse_cnt) * PROD_W'(SCALE);
    assign w_bpm_sat = (|w_product[PROD_W-1:CNT_W]) ? '1 : w_product[CNT_W-1:0];

    always_comb begin
        w_alarm_nxt = 1'b0;
        case (mode)
            2'b01:   w_alarm_nxt = (w_bpm_sat > thr_hi);
            2'b10:   w_alarm_nxt = (w_bpm_sat < thr_lo);
            2'b11:   w_alarm_nxt = (w_bpm_sat < thr_lo) | (w_bpm_sat > thr_hi);
            default: w_alarm_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bpm   <= '0;
            r_valid <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (cls) begin
                r_bpm   <= '0;
                r_alarm <= 1'b0;
            end else if (en_cap) begin
                r_bpm   <= w_bpm_sat;
                r_alarm <= w_alarm_nxt;
                r_valid <= 1'b1;
            end
        end
    end

    assign bpm   = r_bpm;
    assign valid = r_valid;
    assign alarm = r_alarm;

    // ----------------------------------------------- sequential double-dabble
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < BCD_D; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    assign w_bcd_shift = {w_bcd_adj[BCD_W-2:0], r_bin[CNT_W-1]};

    // Displayed digits only change on the final shift, so the display never
    // shows a half-converted value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conv   <= 1'b0;
            r_bin    <= '0;
            r_bcd    <= '0;
            r_sh_cnt <= '0;
            r_digits <= '0;
        end else if (cls) begin
            r_conv   <= 1'b0;
            r_digits <= '0;
        end else if (en_cap) begin
            r_conv   <= 1'b1;
            r_bin    <= w_bpm_sat;
            r_bcd    <= '0;
            r_sh_cnt <= '0;
        end else if (r_conv) begin
            r_bcd    <= w_bcd_shift;
            r_bin    <= {r_bin[CNT_W-2:0], 1'b0};
            r_sh_cnt <= r_sh_cnt + 1'b1;
            if (r_sh_cnt == SH_W'(CNT_W - 1)) begin
                r_conv   <= 1'b0;
                r_digits <= w_bcd_shift[4*DIGITS-1:0];
            end
        end
    end

    // ------------------------------------------------------------ display scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref <= '0;
            r_idx <= '0;
        end else if (r_ref == REF_W'(REFRESH - 1)) begin
            r_ref <= '0;
            r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_ref <= r_ref + 1'b1;
        end
    end

    // A digit is blanked when it and every digit above it are zero; digit 0
    // is excluded so a zero reading still shows "0".
    always_comb begin
        logic v_all_zero;
        v_all_zero   = 1'b1;
        w_blank_mask = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            v_all_zero      = v_all_zero & (r_digits[4*i +: 4] == 4'd0);
            w_blank_mask[i] = v_all_zero;
        end
    end

    always_comb begin
        w_an          = '1;
        w_an[r_idx]   = 1'b0;
        w_digit       = r_digits[r_idx*4 +: 4];
        w_seg         = w_blank_mask[r_idx] ? 7'h00 : seg_decode(w_digit);
    end

    assign an  = w_an;
    assign seg = w_seg;

endmodule
